// File: rtl/iob_uart_loopback_sub.sv
// iob_uart_loopback_sub: IOb subordinate with UART CSR model and internal TX->RX loopback (ports: clk_i, arst_i active-low, cke_i, iob_valid/addr/wdata/wstrb in, iob_ready/rvalid/rdata out)
module iob_uart_loopback_sub #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-3:0] W_CTL = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] W_TX = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] W_RX = (ADDR_W-2)'(2);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic rst_done, soft_rst, tx_en, rx_en, overrun;
  logic [15:0] div, div_eff;
  logic [19:0] cnt, load;
  logic [7:0] tx_byte;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] occ;
  logic acc, wr, rd, wr_ctl, wr_tx, rd_rx, tx_ready, sr_nxt, full, empty, done, push, drop, pop;
  logic [ADDR_W-3:0] word;
  logic [DATA_W-1:0] rdata_c;
  logic unused_bits;
  assign unused_bits = ^{iob_addr_i[1:0], iob_wdata_i[15:9]};
  assign iob_ready_o = rst_done & cke_i;
  assign acc = iob_valid_i & iob_ready_o;
  assign wr = acc & |iob_wstrb_i;
  assign rd = acc & ~|iob_wstrb_i;
  assign word = iob_addr_i[ADDR_W-1:2];
  assign wr_ctl = wr & (word == W_CTL);
  assign wr_tx = wr & (word == W_TX);
  assign rd_rx = rd & (word == W_RX);
  assign tx_ready = tx_en & ~soft_rst & (state == IDLE);
  // a soft-reset write takes effect on its own accepting edge, so a frame finishing there is aborted
  assign sr_nxt = (wr_ctl & iob_wstrb_i[0]) ? iob_wdata_i[0] : soft_rst;
  assign full = occ == (AW+1)'(FIFO_DEPTH);
  assign empty = occ == '0;
  assign done = (state == SEND) & (cnt == 20'd1);
  assign push = done & rx_en & ~full & ~sr_nxt;
  assign drop = done & ~(rx_en & ~full) & ~sr_nxt;
  assign pop = rd_rx & ~empty;
  assign div_eff = (div == 16'd0) ? 16'd1 : div;
  assign load = ({4'b0, div_eff} << 3) + ({4'b0, div_eff} << 1);
  assign rdata_c = (word == W_TX) ? {7'b0, ~empty, 7'b0, tx_ready, 16'b0} :
                   (word == W_RX) ? {23'b0, overrun, empty ? 8'h00 : mem[rptr]} : '0;
  always_ff @(posedge clk_i)
    if (cke_i & push) mem[wptr] <= tx_byte;
  always_ff @(posedge clk_i or negedge arst_i)
    if (!arst_i) begin
      rst_done <= 1'b0;
      iob_rvalid_o <= 1'b0;
      iob_rdata_o <= '0;
      soft_rst <= 1'b0;
      tx_en <= 1'b0;
      rx_en <= 1'b0;
      div <= '0;
      state <= IDLE;
      cnt <= '0;
      tx_byte <= '0;
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
      overrun <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (cke_i) begin
        iob_rvalid_o <= rd;
        if (rd) iob_rdata_o <= rdata_c;
        soft_rst <= sr_nxt;
        if (wr_ctl & iob_wstrb_i[1]) tx_en <= iob_wdata_i[8];
        if (wr_ctl & iob_wstrb_i[2]) div[7:0] <= iob_wdata_i[23:16];
        if (wr_ctl & iob_wstrb_i[3]) div[15:8] <= iob_wdata_i[31:24];
        if (wr_tx & iob_wstrb_i[1]) rx_en <= iob_wdata_i[8];
        if (sr_nxt) state <= IDLE;
        else if (wr_tx & iob_wstrb_i[0] & tx_ready) begin
          tx_byte <= iob_wdata_i[7:0];
          cnt <= load;
          state <= SEND;
        end else if (state == SEND) begin
          cnt <= cnt - 20'd1;
          if (cnt == 20'd1) state <= IDLE;
        end
        if (sr_nxt) begin
          wptr <= '0;
          rptr <= '0;
          occ <= '0;
          overrun <= 1'b0;
        end else begin
          if (push) wptr <= wptr + AW'(1);
          if (pop) rptr <= rptr + AW'(1);
          occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
          if (drop) overrun <= 1'b1;
        end
      end
    end
endmodule
